// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one request at a time to a
// variable-latency instruction memory, and holds the returned word until the
// decoder/immediate generator accept it. Redirects from the branch target
// adder replace the PC and squash any fetch already in flight.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,  // bits [1:0] must be 0
    parameter int          XLEN     = 32               // only 32 supported
) (
    input  logic            clk,
    input  logic            rst_n,
    // instruction memory request/response
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    // downstream instruction handoff
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr_out,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus4,
    // control-flow redirect
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    // statistics
    output logic [31:0]     fetch_count
);

    // Canonical RV32I NOP (addi x0, x0, 0) presented while nothing was fetched.
    localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,  // one cycle after reset before the first request
        ST_FETCH = 2'd1,  // request strobe is on the bus this cycle
        ST_WAIT  = 2'd2,  // request outstanding, waiting for imem_rvalid
        ST_HOLD  = 2'd3   // instruction presented, waiting for instr_ready
    } state_t;

    state_t          state;
    state_t          state_next;

    // Architectural fetch pointer: address of the next (or current) request.
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;

    // Set when the outstanding request belongs to a squashed path; its
    // response must be thrown away and the fetch reissued at the new PC.
    logic            drop;
    logic            drop_next;

    // Captured instruction and the address it came from.
    logic [31:0]     instr_q;
    logic [31:0]     instr_next;
    logic [XLEN-1:0] pc_out_q;
    logic [XLEN-1:0] pc_out_next;

    logic [31:0]     count_q;
    logic [31:0]     count_next;

    // Redirect target is always word-aligned regardless of what arrives.
    logic [XLEN-1:0] redirect_target;
    assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};

    // Decode the handshakes once so the state and datapath logic read alike.
    logic rsp_keep;     // response arrives and is delivered downstream
    logic rsp_discard;  // response arrives but belongs to a squashed path
    logic consume;      // downstream takes the held instruction this cycle

    assign rsp_keep    = (state == ST_WAIT) && imem_rvalid && !drop && !redirect;
    assign rsp_discard = (state == ST_WAIT) && imem_rvalid && (drop || redirect);
    assign consume     = (state == ST_HOLD) && instr_ready;

    // ------------------------------------------------------------------
    // State register.
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic.
    // ------------------------------------------------------------------
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                // The strobe has gone out; a redirect only marks it stale.
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (rsp_keep) begin
                    state_next = ST_HOLD;
                end else if (rsp_discard) begin
                    state_next = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (redirect || instr_ready) begin
                    state_next = ST_FETCH;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Moore outputs decoded from the state.
    // ------------------------------------------------------------------
    always_comb begin
        imem_req    = (state == ST_FETCH);
        instr_valid = (state == ST_HOLD);
    end

    // ------------------------------------------------------------------
    // Datapath next values: PC, squash flag, captured instruction, counter.
    // ------------------------------------------------------------------
    always_comb begin
        pc_next     = pc;
        drop_next   = drop;
        instr_next  = instr_q;
        pc_out_next = pc_out_q;
        count_next  = count_q;

        unique case (state)
            ST_FETCH: begin
                if (redirect) begin
                    pc_next   = redirect_target;
                    drop_next = 1'b1;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    pc_next = redirect_target;
                    // If the response lands in the same cycle it is the stale
                    // one, so nothing remains to be dropped afterwards.
                    drop_next = !imem_rvalid;
                end else if (imem_rvalid) begin
                    if (drop) begin
                        drop_next = 1'b0;
                    end else begin
                        instr_next  = imem_rdata;
                        pc_out_next = pc;
                    end
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    pc_next = redirect_target;
                end else if (instr_ready) begin
                    pc_next = pc + PC_STEP;
                end
                // A redirect coinciding with instr_ready still hands the
                // instruction over, so it is counted either way.
                if (consume) begin
                    count_next = count_q + 32'd1;
                end
            end
            default: begin
                // ST_IDLE: nothing moves until the first request.
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            drop     <= 1'b0;
            instr_q  <= NOP_INSTR;
            pc_out_q <= RESET_PC;
            count_q  <= 32'd0;
        end else begin
            pc       <= pc_next;
            drop     <= drop_next;
            instr_q  <= instr_next;
            pc_out_q <= pc_out_next;
            count_q  <= count_next;
        end
    end

    // ------------------------------------------------------------------
    // Output wiring.
    // ------------------------------------------------------------------
    assign imem_addr   = pc;
    assign instr_out   = instr_q;
    assign pc_out      = pc_out_q;
    assign pc_plus4    = pc_out_q + PC_STEP;  // wraps modulo 2^XLEN
    assign fetch_count = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a transaction-level model of the
// architectural PC stream plus directed scenarios with literal expectations.
module tb_instr_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata  = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        redirect    = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] fetch_count;

    // Second instance for PC wrap-around at the top of the address space.
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_rvalid = 1'b0;
    logic        w_req_d  = 1'b0;
    logic        w_valid;
    logic [31:0] w_out;
    logic [31:0] w_pc;
    logic [31:0] w_p4;
    logic [31:0] w_count;

    int vectors     = 0;
    int miscompares = 0;
    int lat         = 1;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .XLEN(32)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_out(instr_out), .pc_out(pc_out), .pc_plus4(pc_plus4),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .fetch_count(fetch_count)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .XLEN(32)) u_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_rvalid(w_rvalid), .imem_rdata(32'h0000_0013),
        .instr_valid(w_valid), .instr_ready(1'b1),
        .instr_out(w_out), .pc_out(w_pc), .pc_plus4(w_p4),
        .redirect(1'b0), .redirect_pc(32'h0),
        .fetch_count(w_count)
    );

    // Memory contents as a function of address; address 0 holds addi x1,x0,5.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return {a[29:0], 2'b11} ^ 32'h5A00_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: DUT event never arrived within the cycle budget", name);
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!instr_valid && n < 30) begin
            tick();
            @(negedge clk);
            n++;
        end
        if (!instr_valid) timeout(name);
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!imem_req && n < 30) begin
            tick();
            @(negedge clk);
            n++;
        end
        if (!imem_req) timeout(name);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req"},   {31'b0, imem_req},    32'h0);
        check({tag, "_valid"}, {31'b0, instr_valid}, 32'h0);
        check({tag, "_instr"}, instr_out,            32'h0000_0013);
        check({tag, "_pc"},    pc_out,               32'h0);
        check({tag, "_pc4"},   pc_plus4,             32'h4);
        check({tag, "_count"}, fetch_count,          32'h0);
    endtask

    // Memory responder: one outstanding request, answered `lat` cycles later.
    // It deliberately survives a DUT reset so a late response can be injected.
    int          pend_cnt  = 0;
    logic [31:0] pend_addr = 32'h0;
    always begin
        tick();
        imem_rvalid = 1'b0;
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pend_addr);
            end
        end
        if (imem_req === 1'b1) begin
            pend_addr = imem_addr;
            pend_cnt  = lat;
        end
    end

    // Latency-1 responder for the wrap instance.
    always begin
        tick();
        w_rvalid = w_req_d;
        w_req_d  = w_req;
    end

    // Reference model: the architectural PC stream. Every request must target
    // the current expected PC, every presented instruction must be the memory
    // word at that PC, and the counter must equal the accepted handoffs.
    logic [31:0] exp_pc   = 32'h0;
    logic [31:0] accepted = 32'h0;
    logic        prev_req = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_pc   = 32'h0;
            accepted = 32'h0;
            prev_req = 1'b0;
        end else begin
            check("m_count", fetch_count, accepted);
            check("m_req_and_valid", {31'b0, imem_req & instr_valid}, 32'h0);
            if (imem_req) begin
                check("m_req_addr", imem_addr, exp_pc);
                check("m_req_one_cycle", {31'b0, prev_req}, 32'h0);
            end
            if (instr_valid) begin
                check("m_pc_out", pc_out, exp_pc);
                check("m_instr", instr_out, mem_word(exp_pc));
                check("m_pc_plus4", pc_plus4, exp_pc + 32'd4);
            end
            if (redirect) begin
                if (instr_valid && instr_ready) accepted = accepted + 32'd1;
                exp_pc = redirect_pc & ~32'd3;
            end else if (instr_valid && instr_ready) begin
                accepted = accepted + 32'd1;
                exp_pc   = exp_pc + 32'd4;
            end
            prev_req = imem_req;
        end
    end

    // Wrap scenario on the second instance.
    initial begin : wrap_chk
        bit found = 1'b0;
        @(posedge rst_n);
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (w_valid) found = 1'b1;
        end
        if (!found) begin
            timeout("wrap_valid");
        end else begin
            check("wrap_pc_out", w_pc, 32'hFFFF_FFFC);
            check("wrap_pc_plus4", w_p4, 32'h0);
            found = 1'b0;
            for (int i = 0; i < 5 && !found; i++) begin
                @(negedge clk);
                if (w_req) found = 1'b1;
            end
            if (!found) timeout("wrap_req");
            else begin
                check("wrap_next_addr", w_addr, 32'h0);
                check("wrap_count", w_count, 32'h1);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Directed scenarios.
    initial begin : stim
        int n;
        rst_n       = 1'b0;
        instr_ready = 1'b1;
        lat         = 1;
        repeat (2) tick();
        @(negedge clk);
        check_reset_values("rst");

        // Reset release, latency 1, ready high.
        tick(); rst_n = 1'b1;
        @(negedge clk); check("c1_req", {31'b0, imem_req}, 32'h0);
        tick(); @(negedge clk);
        check("c2_req", {31'b0, imem_req}, 32'h1);
        check("c2_addr", imem_addr, 32'h0);
        tick(); @(negedge clk);
        check("c3_valid", {31'b0, instr_valid}, 32'h0);
        tick(); @(negedge clk);
        check("c4_valid", {31'b0, instr_valid}, 32'h1);
        check("c4_instr", instr_out, 32'h0050_0093);
        check("c4_pc", pc_out, 32'h0);
        check("c4_pc4", pc_plus4, 32'h4);
        tick(); instr_ready = 1'b0;
        @(negedge clk);
        check("c5_req_addr", imem_addr, 32'h4);
        check("c5_count", fetch_count, 32'h1);

        // Backpressure in HOLD.
        wait_valid("bp_valid");
        check("bp_pc", pc_out, 32'h4);
        for (int i = 0; i < 5; i++) begin
            tick(); @(negedge clk);
            check("bp_hold_valid", {31'b0, instr_valid}, 32'h1);
            check("bp_hold_req", {31'b0, imem_req}, 32'h0);
            check("bp_hold_instr", instr_out, mem_word(32'h4));
            check("bp_hold_pc", pc_out, 32'h4);
        end
        tick(); instr_ready = 1'b1;
        @(negedge clk);
        tick(); instr_ready = 1'b0;
        @(negedge clk);
        check("bp_next_addr", imem_addr, 32'h8);
        check("bp_count", fetch_count, 32'h2);

        // Redirect together with instr_ready in HOLD at pc 8.
        wait_valid("rr_valid");
        check("rr_pc", pc_out, 32'h8);
        tick(); instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h40; lat = 3;
        @(negedge clk);
        tick(); instr_ready = 1'b0; redirect = 1'b0;
        @(negedge clk);
        check("rr_req", {31'b0, imem_req}, 32'h1);
        check("rr_addr", imem_addr, 32'h40);
        check("rr_count", fetch_count, 32'h3);

        // Redirect in WAIT with a misaligned target, latency 3.
        tick(); redirect = 1'b1; redirect_pc = 32'h0000_0102;
        @(negedge clk);
        tick(); redirect = 1'b0;
        @(negedge clk);
        n = 0;
        while (!imem_req && n < 20) begin
            check("drop_no_valid", {31'b0, instr_valid}, 32'h0);
            tick(); @(negedge clk);
            n++;
        end
        if (!imem_req) timeout("drop_req");
        else check("drop_addr", imem_addr, 32'h100);
        wait_valid("drop_valid");
        check("drop_pc", pc_out, 32'h100);
        check("drop_instr", instr_out, mem_word(32'h100));

        // Accept, then redirect during the following FETCH cycle.
        tick(); instr_ready = 1'b1;
        @(negedge clk);
        tick(); instr_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h200;
        @(negedge clk);
        check("fr_req", {31'b0, imem_req}, 32'h1);
        check("fr_addr_not_cancelled", imem_addr, 32'h104);
        tick(); redirect = 1'b0;
        @(negedge clk);
        wait_req("fr_req2");
        check("fr_addr2", imem_addr, 32'h200);

        // Redirect in the same cycle the (latency 3) response arrives.
        tick(); tick();
        tick(); redirect = 1'b1; redirect_pc = 32'h300;
        @(negedge clk);
        tick(); redirect = 1'b0;
        @(negedge clk);
        check("rv_req", {31'b0, imem_req}, 32'h1);
        check("rv_addr", imem_addr, 32'h300);
        instr_ready = 1'b1;
        wait_valid("rv_valid");
        check("rv_pc", pc_out, 32'h300);

        // Asynchronous reset during WAIT, followed by a late response.
        tick(); @(negedge clk);
        check("ar_addr", imem_addr, 32'h304);
        tick(); rst_n = 1'b0;
        @(negedge clk);
        check_reset_values("ar");
        tick(); rst_n = 1'b1;
        @(negedge clk);
        check("ar_c1_req", {31'b0, imem_req}, 32'h0);
        tick(); @(negedge clk);
        check("ar_c2_req", {31'b0, imem_req}, 32'h1);
        check("ar_c2_addr", imem_addr, 32'h0);
        check("ar_c2_valid", {31'b0, instr_valid}, 32'h0);
        wait_valid("ar_valid");
        check("ar_pc", pc_out, 32'h0);
        check("ar_instr", instr_out, 32'h0050_0093);
        repeat (12) tick();
        @(negedge clk);
        check("end_count_nonzero", {31'b0, fetch_count != 32'h0}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Multi-cycle instruction fetch stage directly upstream of the immediate generator and decoder.
- Owns the PC register and issues one request at a time to a variable-latency instruction memory.
- Holds the returned 32-bit instruction until downstream accepts it; the decoder and immediate generator consume instr_out[31:7] and instr_out[6:0].
- Accepts PC redirects from the branch target adder (PC + ImmExt) and squashes stale fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
XLEN, 32, PC/address width; only 32 supported.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
imem_req  output  1  fetch request strobe, one cycle per request
imem_addr  output  32  fetch address, valid while imem_req=1
imem_rvalid  input  1  read data valid, one cycle, ≥1 cycle after imem_req
imem_rdata  input  32  instruction word, valid with imem_rvalid
instr_valid  output  1  instr_out/pc_out hold a valid instruction
instr_ready  input  1  downstream accepts instruction this cycle
instr_out  output  32  fetched instruction
pc_out  output  32  address of instr_out
pc_plus4  output  32  pc_out + 4, wraps modulo 2^32
redirect  input  1  branch/jump taken, one-cycle pulse
redirect_pc  input  32  new PC; bits [1:0] forced to 0 internally
fetch_count  output  32  count of instructions handed downstream, wraps

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, pc=RESET_PC, drop=0, instr_out=32'h0000_0013 (NOP), pc_out=RESET_PC, instr_valid=0, imem_req=0, fetch_count=0.
- Outputs are Moore: imem_req=(state==FETCH), imem_addr=pc, instr_valid=(state==HOLD).
- IDLE: unconditional transition to FETCH on the next edge. First imem_req is high in the 2nd cycle after rst_n deasserts.
- FETCH: imem_req=1 for exactly one cycle, then WAIT. A redirect in this cycle does not cancel the request: pc<=redirect_pc&~3, drop<=1, go WAIT.
- WAIT: hold until imem_rvalid.
  - imem_rvalid with drop=0: instr_out<=imem_rdata, pc_out<=pc, go HOLD.
  - imem_rvalid with drop=1: discard data, drop<=0, go FETCH.
  - Redirect without rvalid: pc<=target, drop<=1.
  - Redirect with rvalid in the same cycle: data discarded, pc<=target, drop<=0, go FETCH.
- HOLD: instr_out/pc_out stable while instr_valid=1 and instr_ready=0.
  - instr_ready=1: pc<=pc+4, fetch_count+=1, go FETCH.
  - Redirect: pc<=target, go FETCH, no increment.
  - Redirect and instr_ready in the same cycle: redirect wins, instruction counted as consumed (fetch_count+=1).
- Throughput: at most 1 instruction per 3 cycles (FETCH, WAIT≥1, HOLD).
- One outstanding request only. imem_rvalid in IDLE/FETCH/HOLD is a protocol error and is ignored.
- PC arithmetic is 32-bit unsigned and wraps (32'hFFFF_FFFC+4=0).
- Asynchronous reset mid-fetch returns all state to reset values immediately. A late rvalid after reset is ignored (state≠WAIT).

Test Plan:
- Reset release, memory latency 1, rdata=32'h00500093, instr_ready=1 -> imem_req in cycle 2 with addr 0; instr_valid in cycle 4 with instr_out=32'h00500093, pc_out=0, pc_plus4=4; next request addr=4; fetch_count=1.
- Backpressure: instr_ready=0 for 5 cycles in HOLD -> instr_out/pc_out constant, no imem_req. Then ready=1 -> fetch_count increments once, next addr=pc+4.
- Redirect in WAIT with redirect_pc=32'h0000_0102, latency 3 -> returned data dropped, instr_valid stays 0, next request addr=32'h0000_0100.
- Redirect and instr_ready together in HOLD at pc=8, target=32'h40 -> next imem_addr=32'h40, fetch_count+1.
- Wrap: RESET_PC=32'hFFFF_FFFC, instruction accepted -> pc_plus4=0, next imem_addr=0.
- rst_n asserted during WAIT, then rvalid pulses -> outputs at reset values, pulse ignored, fetch restarts at RESET_PC.
